// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// The optional timeout path is selected by the WB_CMD_MASTER_TIMEOUT_EN macro.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bus cycles without ack before a transfer is abandoned
    localparam int unsigned DEF_TIMEOUT = 255;

    // Response codes carried on rsp_err
    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_TMO = 1'b1;

    // Byte-enable width for a given data width
    function automatic int sel_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response channel plus Wishbone master bus, bundled for the
// wb_cmd_master port list. "master" is the block's view, "slave" the
// view of whatever drives commands and answers the bus.
interface wb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import wb_cmd_pkg::*;

    localparam int SEL_W = sel_w(DATA_W);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_adr;
    logic [DATA_W-1:0] cmd_dat;
    logic [SEL_W-1:0]  cmd_sel;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_err;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic [DATA_W-1:0] wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

endinterface

// File: rtl/wb_cmd_master_timeout_cnt.sv
// Bus-cycle watchdog: cleared when a command is accepted, counts while
// enabled, and flags the terminal count TERM-1 so the owner sees exactly
// TERM enabled cycles before tc. Used only with WB_CMD_MASTER_TIMEOUT_EN.
module wb_timeout_cnt
    import wb_cmd_pkg::*;
#(
    parameter int unsigned TERM = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [15:0] cnt_q, cnt_d;

    assign tc = (cnt_q == 16'(TERM - 1));

    // Next count: clear wins, then hold at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: takes one command at a time,
// runs it on the bus and returns read data or an error on a held response.
// Define WB_CMD_MASTER_TIMEOUT_EN to add the no-ack abort path.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_cmd_master_if.master bus
);

    localparam int SEL_W = sel_w(DATA_W);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic accept;
    logic tmo_hit;

    // ready_q is only ever set while IDLE, so it alone qualifies acceptance
    assign accept = ready_q && bus.cmd_valid;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wb_timeout_cnt #(.TERM(TIMEOUT)) u_timeout_cnt (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (accept),
        .en  (state_q == ST_BUS),
        .tc  (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

    assign bus.cmd_ready = ready_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        xfer_cnt_d  = xfer_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    sel_d   = bus.cmd_sel;
                end
            end
            ST_BUS: begin
                // Ack is checked first so a late ack on the terminal cycle still completes
                if (bus.wbm_ack_i) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
                    rsp_err_d   = RSP_OK;
                    xfer_cnt_d  = xfer_cnt_q + 16'd1;
                end else if (tmo_hit) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = RSP_TMO;
                    xfer_cnt_d  = xfer_cnt_q + 16'd1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        // Registered decode of the next state; low through reset and the cycle after
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset also drops any pending response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master. Timeout scenarios run only when
// WB_CMD_MASTER_TIMEOUT_EN is defined; otherwise a long no-ack wait is run.
module tb_wb_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_xfer = 0;
    int   ncyc;

    wb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.master)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Counts bus cycles with cyc high; acks in cycle ack_at (0 = never)
    task automatic run_bus(input int ack_at, input logic [31:0] rdata, output int n);
        n = 0;
        bus.wbm_dat_i = rdata;
        while (bus.wbm_cyc_o === 1'b1 && n < 100) begin
            n++;
            bus.wbm_ack_i = (n == ack_at);
            tick();
            bus.wbm_ack_i = 1'b0;
        end
        bus.wbm_dat_i = '0;
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.wbm_dat_i = '0;
        bus.wbm_ack_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("rst_adr", bus.wbm_adr_o, 32'h0);
        check("rst_sel", 32'(bus.wbm_sel_o), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_dat", bus.rsp_dat, 32'h0);
        check("rst_xfer_cnt", 32'(dut.xfer_cnt_q), 32'd0);
        check("rst_err_cnt", 32'(dut.err_cnt_q), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

        // Zero-wait read
        send_cmd(1'b0, 32'h2600_0000, 32'h0, 4'hF);
        check("rd_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        check("rd_stb", 32'(bus.wbm_stb_o), 32'd1);
        check("rd_adr", bus.wbm_adr_o, 32'h2600_0000);
        check("rd_we", 32'(bus.wbm_we_o), 32'd0);
        check("rd_busy", 32'(bus.cmd_ready), 32'd0);
        run_bus(1, 32'h1234_5678, ncyc);
        exp_xfer++;
        check("rd_ncyc", 32'(ncyc), 32'd1);
        check("rd_cyc_drop", 32'(bus.wbm_cyc_o), 32'd0);
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rsp_dat", bus.rsp_dat, 32'h1234_5678);
        check("rd_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rd_xfer_cnt", 32'(dut.xfer_cnt_q), 32'd1);
        take_rsp();
        check("rd_rsp_taken", 32'(bus.rsp_valid), 32'd0);
        check("rd_ready_again", 32'(bus.cmd_ready), 32'd1);

        // Write with two wait states
        send_cmd(1'b1, 32'h2600_000C, 32'hA5A5_0000, 4'hF);
        check("wr_dat_o", bus.wbm_dat_o, 32'hA5A5_0000);
        check("wr_we", 32'(bus.wbm_we_o), 32'd1);
        check("wr_sel", 32'(bus.wbm_sel_o), 32'hF);
        run_bus(3, 32'hFFFF_FFFF, ncyc);
        exp_xfer++;
        check("wr_ncyc", 32'(ncyc), 32'd3);
        check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("wr_rsp_dat", bus.rsp_dat, 32'h0);
        check("wr_dat_hold", bus.wbm_dat_o, 32'hA5A5_0000);
        take_rsp();

        // Stray ack while idle
        bus.wbm_ack_i = 1'b1;
        tick();
        bus.wbm_ack_i = 1'b0;
        check("idle_ack_rsp", 32'(bus.rsp_valid), 32'd0);
        check("idle_ack_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("idle_ack_ready", 32'(bus.cmd_ready), 32'd1);

        // Backpressure with a second command waiting
        send_cmd(1'b0, 32'h2600_0004, 32'h0, 4'h3);
        run_bus(1, 32'hCAFE_F00D, ncyc);
        exp_xfer++;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h2600_0008;
        bus.cmd_sel   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_dat", bus.rsp_dat, 32'hCAFE_F00D);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_hs_rsp", 32'(bus.rsp_valid), 32'd0);
        check("bp_hs_ready", 32'(bus.cmd_ready), 32'd1);
        check("bp_hs_no_accept", 32'(bus.wbm_cyc_o), 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_accept_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        check("bp_accept_adr", bus.wbm_adr_o, 32'h2600_0008);
        run_bus(1, 32'h0BAD_F00D, ncyc);
        exp_xfer++;
        check("bp2_rsp_dat", bus.rsp_dat, 32'h0BAD_F00D);
        take_rsp();
        check("bp_xfer_cnt", 32'(dut.xfer_cnt_q), 32'(exp_xfer));

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // Slave never acks
        send_cmd(1'b0, 32'h2600_0010, 32'h0, 4'hF);
        run_bus(0, 32'hDEAD_BEEF, ncyc);
        exp_xfer++;
        check("tmo_ncyc", 32'(ncyc), 32'(TMO));
        check("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("tmo_rsp_dat", bus.rsp_dat, 32'h0);
        check("tmo_err_cnt", 32'(dut.err_cnt_q), 32'd1);
        take_rsp();

        // Ack on the terminal timeout cycle
        send_cmd(1'b0, 32'h2600_0014, 32'h0, 4'hF);
        run_bus(TMO, 32'h7777_1111, ncyc);
        exp_xfer++;
        check("tc_ack_ncyc", 32'(ncyc), 32'(TMO));
        check("tc_ack_err", 32'(bus.rsp_err), 32'd0);
        check("tc_ack_dat", bus.rsp_dat, 32'h7777_1111);
        check("tc_ack_err_cnt", 32'(dut.err_cnt_q), 32'd1);
        take_rsp();
`else
        // Without the watchdog the master waits as long as it takes
        send_cmd(1'b0, 32'h2600_0010, 32'h0, 4'hF);
        run_bus(20, 32'h7777_1111, ncyc);
        exp_xfer++;
        check("long_ncyc", 32'(ncyc), 32'd20);
        check("long_err", 32'(bus.rsp_err), 32'd0);
        check("long_dat", bus.rsp_dat, 32'h7777_1111);
        check("long_err_cnt", 32'(dut.err_cnt_q), 32'd0);
        take_rsp();
`endif
        check("xfer_cnt", 32'(dut.xfer_cnt_q), 32'(exp_xfer));

        // Reset pulse during BUS, then a late ack
        send_cmd(1'b0, 32'h2600_0020, 32'h0, 4'hF);
        tick();
        check("mid_cyc_before", 32'(bus.wbm_cyc_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_ready_low", 32'(bus.cmd_ready), 32'd0);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h5555_5555;
        tick();
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("late_ack_rsp", 32'(bus.rsp_valid), 32'd0);
        check("late_ack_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("mid_rst_xfer_cnt", 32'(dut.xfer_cnt_q), 32'd0);

        // Recovery read
        send_cmd(1'b0, 32'h2600_0024, 32'h0, 4'hF);
        run_bus(1, 32'h600D_CAFE, ncyc);
        check("rec_rsp_dat", bus.rsp_dat, 32'h600D_CAFE);
        check("rec_xfer_cnt", 32'(dut.xfer_cnt_q), 32'd1);
        take_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-transfer bus master driving the user-project slave port (wbs_* on user_proj_example). It sits between a simple valid/ready command source (test sequencer, LA-driven controller or firmware bridge) and the slave, and runs one read or write at a time. It returns read data or a timeout error on a valid/ready response channel. It is the initiator counterpart of the user-project Wishbone responder and replaces hand-wiggled bus stimulus in benches.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; sel width is DATA_W/8
- TIMEOUT, 255, BUS-state cycles without ack before abort (1..65535)

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted this edge if cmd_valid
- cmd_we  in  1  1 write, 0 read
- cmd_adr  in  ADDR_W  target address
- cmd_dat  in  DATA_W  write data
- cmd_sel  in  DATA_W/8  byte enables
- rsp_valid  out  1  response held until taken
- rsp_ready  in  1  response consumer ready
- rsp_dat  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  transfer aborted by timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe, write enable
- wbm_adr_o  out  ADDR_W;  wbm_dat_o  out  DATA_W;  wbm_sel_o  out  DATA_W/8
- wbm_dat_i  in  DATA_W  slave read data
- wbm_ack_i  in  1  slave acknowledge

## Operation
- States: IDLE, BUS, RESP. Reset -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid, register we/adr/dat/sel into the wbm_* outputs, assert cyc/stb, go to BUS.
- BUS: cyc=stb=1 with constant adr/dat/sel/we. On wbm_ack_i=1, drop cyc/stb. rsp_dat takes wbm_dat_i for reads and 0 for writes. rsp_err=0. Go to RESP.
- BUS timeout: a counter clears on entry and increments each BUS cycle without ack. When it reaches TIMEOUT-1 without ack, drop cyc/stb, set rsp_err=1 and rsp_dat=0, go to RESP.
- If ack and timeout occur in the same cycle, ack wins: normal completion, rsp_err=0.
- RESP: rsp_valid=1 and rsp_dat/rsp_err stay stable. The state leaves on rsp_valid&&rsp_ready and goes to IDLE. cmd_ready=0.
- wbm_ack_i outside BUS is ignored.
- Only one transfer is outstanding. wbm_sel_o, wbm_adr_o and wbm_dat_o hold their last values when idle. wbm_dat_o is valid only when wbm_we_o=1.
- A counter holds the transfer count (16-bit) and an error count (8-bit, saturating). The counters are observable by hierarchical reference only.

## Timing
- Reset values: cmd_ready=0 during reset and 1 on the first cycle after it; cyc/stb/we=0, adr/dat/sel=0; rsp_valid=0, rsp_dat=0, rsp_err=0; counters 0.
- Reset mid-transfer: on the next edge cyc/stb=0, state=IDLE, any pending response is discarded.
- Accept edge N: cyc/stb high from N.
- Ack sampled at edge M≥N+1: cyc/stb low and rsp_valid high from M.
- A zero-wait slave gives one bus cycle. The minimum cycle count per transfer is 3: IDLE, BUS, RESP with rsp_ready high.
- Timeout: cyc/stb stay high for exactly TIMEOUT cycles.
- All outputs are registered. cmd_ready is decoded from the state register.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN defined: the timeout counter and abort path are present, and rsp_err behaves as above.
- Not defined: no counter. BUS waits for ack indefinitely, rsp_err is tied 0, and the error count stays 0.

## Structure
- Package wb_cmd_pkg holds:
  - state enum (IDLE/BUS/RESP)
  - default TIMEOUT
  - response-code constants
  - the DATA_W/8 sel-width helper
- Sub-module wb_timeout_cnt holds the clear/enable/terminal-count counter. It is instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

## Test plan
- Write: cmd we=1, adr=0x2600000C, dat=0xA5A50000, sel=0xF. The slave acks after 2 wait cycles. Required:
  - cyc/stb high for 3 cycles
  - wbm_dat_o=0xA5A50000
  - rsp_valid with rsp_err=0, rsp_dat=0
- Read: cmd we=0, adr=0x26000000. The slave returns 0x12345678 with zero-wait ack. Required:
  - rsp_dat=0x12345678 one cycle after cyc
  - transfer count increments to 1
- Backpressure: rsp_ready low for 5 cycles. Required:
  - rsp_valid and rsp_dat stable throughout
  - cmd_ready=0 throughout
  - a second cmd_valid is not accepted until the cycle after the handshake
- Timeout with macro defined and TIMEOUT=8, slave never acks. Required:
  - cyc high for exactly 8 cycles
  - rsp_err=1, rsp_dat=0
  - error count=1
- Ack on the terminal timeout cycle. Required: normal completion with rsp_err=0.
- wb_rst_i pulsed for 1 cycle while in BUS. Required:
  - cyc/stb=0 and rsp_valid=0 after the next edge
  - cmd_ready=1 after the following edge
  - a late ack is ignored
